// File: rtl/s_aes_iter_core_if.sv
// -----------------------------------------------------------------------------
// s_aes_iter_core_if
// Purpose : Groups the job-side and result-side handshake of the iterative
//           S-AES engine into one bundle. Carries LANES 16-bit blocks.
// Signals :
//   in_valid  master->slave  source presents a job
//   in_ready  slave->master  engine can accept a job
//   in_mode   master->slave  0 = encrypt, 1 = decrypt
//   in_key    master->slave  16-bit cipher key
//   in_data   master->slave  DW-bit input blocks, lane i = [16i+15:16i]
//   out_valid slave->master  result available
//   out_ready master->slave  sink accepts result
//   out_data  slave->master  DW-bit result, same lane mapping
//   busy      slave->master  engine is not idle
// Modports: master = source/sink side, slave = engine side.
// -----------------------------------------------------------------------------
interface s_aes_iter_core_if #(
    parameter int LANES = 1
);
    localparam int DW = 16 * LANES;

    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [15:0]   in_key;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    modport master (
        output in_valid,
        output in_mode,
        output in_key,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_mode,
        input  in_key,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );
endinterface

// File: rtl/s_aes_iter_core.sv
// -----------------------------------------------------------------------------
// s_aes_iter_core
// Purpose : Sequential Simplified-AES engine. One key and one mode are shared
//           by LANES independent 16-bit blocks. The initial AddRoundKey happens
//           on the accept edge, then one round per clock (RND1, RND2), and the
//           result is held in DONE until the sink takes it.
// Ports   :
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset; aborts any job in flight
//   io_bus  s_aes_iter_core_if.slave (job input, result output, busy)
// Parameters:
//   LANES   number of parallel 16-bit blocks (1..8); must match the interface
// Nibble layout of a block: s00=[15:12], s10=[11:8], s01=[7:4], s11=[3:0].
// Columns are {s00,s10} and {s01,s11}.
// -----------------------------------------------------------------------------
module s_aes_iter_core #(
    parameter int LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    s_aes_iter_core_if.slave      io_bus
);
    localparam int DW = 16 * LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RND1 = 2'd1,
        RND2 = 2'd2,
        DONE = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Cipher primitives
    // -------------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
            4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
            4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
            4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
            4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
            4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
            4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sub_nib16(input logic [15:0] s);
        return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] inv_sub_nib16(input logic [15:0] s);
        return {inv_sbox(s[15:12]), inv_sbox(s[11:8]),
                inv_sbox(s[7:4]),   inv_sbox(s[3:0])};
    endfunction

    // Swapping s10 and s11 is its own inverse, so one function serves both
    // ShiftRows and InvShiftRows.
    function automatic logic [15:0] shift_rows(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    // GF(2^4) multiply, modulus x^4+x+1 (x^4 folds back to 4'h3).
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // Column matrix [1 4; 4 1].
    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {s[15:12] ^ gf_mul(4'h4, s[11:8]),
                gf_mul(4'h4, s[15:12]) ^ s[11:8],
                s[7:4] ^ gf_mul(4'h4, s[3:0]),
                gf_mul(4'h4, s[7:4]) ^ s[3:0]};
    endfunction

    // Column matrix [9 2; 2 9].
    function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
        return {gf_mul(4'h9, s[15:12]) ^ gf_mul(4'h2, s[11:8]),
                gf_mul(4'h2, s[15:12]) ^ gf_mul(4'h9, s[11:8]),
                gf_mul(4'h9, s[7:4])   ^ gf_mul(4'h2, s[3:0]),
                gf_mul(4'h2, s[7:4])   ^ gf_mul(4'h9, s[3:0])};
    endfunction

    function automatic logic [7:0] sub_rot_byte(input logic [7:0] b);
        // RotNib then SubNib on one key byte.
        return {sbox(b[3:0]), sbox(b[7:4])};
    endfunction

    // Returns {K0, K1, K2}.
    function automatic logic [47:0] key_expand(input logic [15:0] key);
        logic [7:0] w0, w1, w2, w3, w4, w5;
        w0 = key[15:8];
        w1 = key[7:0];
        w2 = w0 ^ 8'h80 ^ sub_rot_byte(w1);
        w3 = w2 ^ w1;
        w4 = w2 ^ 8'h30 ^ sub_rot_byte(w3);
        w5 = w4 ^ w3;
        return {w0, w1, w2, w3, w4, w5};
    endfunction

    // -------------------------------------------------------------------------
    // Registers and wires
    // -------------------------------------------------------------------------
    state_e        r_state;
    state_e        w_next_state;
    logic          w_accept;

    logic          r_mode;
    logic [15:0]   r_k0;
    logic [15:0]   r_k1;
    logic [15:0]   r_k2;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_out;

    logic [47:0]   w_keys;
    logic [DW-1:0] w_init;
    logic [DW-1:0] w_rnd1;
    logic [DW-1:0] w_rnd2;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking '<=' so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state     = r_state;
        w_accept         = 1'b0;
        io_bus.in_ready  = 1'b0;
        io_bus.out_valid = 1'b0;
        io_bus.busy      = 1'b1;
        case (r_state)
            IDLE: begin
                io_bus.in_ready = 1'b1;
                io_bus.busy     = 1'b0;
                if (io_bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = RND1;
                end
            end
            RND1: w_next_state = RND2;
            RND2: w_next_state = DONE;
            DONE: begin
                // out_valid is exactly "in DONE"; it comes straight from the
                // state flops, so it is glitch-free and cleared by reset.
                io_bus.out_valid = 1'b1;
                if (io_bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Round datapath, identical per lane
    // -------------------------------------------------------------------------
    always_comb begin
        w_keys = key_expand(io_bus.in_key);
        w_init = '0;
        w_rnd1 = '0;
        w_rnd2 = '0;
        for (int l = 0; l < LANES; l++) begin
            // Whitening key: K0 for encrypt, K2 for decrypt.
            w_init[16*l +: 16] = io_bus.in_data[16*l +: 16] ^
                                 (io_bus.in_mode ? w_keys[15:0] : w_keys[47:32]);
            if (r_mode) begin
                w_rnd1[16*l +: 16] = inv_mix_col(inv_sub_nib16(shift_rows(r_data[16*l +: 16])) ^ r_k1);
                w_rnd2[16*l +: 16] = inv_sub_nib16(shift_rows(r_data[16*l +: 16])) ^ r_k0;
            end else begin
                w_rnd1[16*l +: 16] = mix_col(shift_rows(sub_nib16(r_data[16*l +: 16]))) ^ r_k1;
                w_rnd2[16*l +: 16] = shift_rows(sub_nib16(r_data[16*l +: 16])) ^ r_k2;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers. Mode and round keys are latched on accept, so input
    // changes while a job is in flight cannot disturb it.
    // -------------------------------------------------------------------------
    // NOTE: the key and state registers are plain flops, not a memory array,
    // so they take the async reset; clearing them guarantees no stale result
    // or key material is visible after an aborted job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
            r_k0   <= '0;
            r_k1   <= '0;
            r_k2   <= '0;
            r_data <= '0;
            r_out  <= '0;
        end else begin
            if (w_accept) begin
                r_mode <= io_bus.in_mode;
                r_k0   <= w_keys[47:32];
                r_k1   <= w_keys[31:16];
                r_k2   <= w_keys[15:0];
                r_data <= w_init;
            end
            if (r_state == RND1) begin
                r_data <= w_rnd1;
            end
            // out_data only changes at the RND2 edge and keeps its value after
            // the result is consumed.
            if (r_state == RND2) begin
                r_out <= w_rnd2;
            end
        end
    end

    assign io_bus.out_data = r_out;

endmodule

// File: doc/s_aes_iter_core.md
Name: s_aes_iter_core

Overview:
- Multi-lane, sequential Simplified-AES engine: one key schedule and one encrypt/decrypt mode shared by LANES independent 16-bit blocks.
- Key expansion, AddRoundKey, NibbleSub, ShiftRows and MixColumns are computed one round per clock, with a valid/ready handshake on both sides.
- Supersedes the purely combinational S-AES encryptor: adds decryption, registered rounds, lane scaling and flow control.
- Sits between the block-cipher front end (data/key source) and the result sink.

Parameters:
LANES, 1, number of 16-bit blocks processed in parallel under one key (1..8)
DW, 16*LANES, derived data width; not to be overridden

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  source presents a job
in_ready  out  1  engine can accept a job
in_mode  in  1  0 = encrypt, 1 = decrypt
in_key  in  16  cipher key
in_data  in  DW  plaintext (enc) or ciphertext (dec); lane i = bits [16i+15:16i]
out_valid  out  1  result available
out_ready  in  1  sink accepts result
out_data  out  DW  result, same lane mapping
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous and active-low:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_data=0; round keys and state registers are cleared to 0.
  - Reset asserted mid-job aborts the job; no partial result is ever presented.
- Nibble layout: s00=[15:12], s10=[11:8], s01=[7:4], s11=[3:0].
  - ShiftRows and InvShiftRows both swap [11:8] with [3:0].
- S-box (0..F): 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- Inverse S-box (0..F): A,5,9,B,1,7,8,F,6,0,2,3,C,4,D,E.
- Key expansion (bytes w0=key[15:8], w1=key[7:0]):
  - w2 = w0 ^ 8'h80 ^ SubNib(RotNib(w1)); w3 = w2 ^ w1.
  - w4 = w2 ^ 8'h30 ^ SubNib(RotNib(w3)); w5 = w4 ^ w3.
  - K0={w0,w1}, K1={w2,w3}, K2={w4,w5}.
  - RotNib swaps the two nibbles of a byte.
- MixColumns per column: matrix [1 4; 4 1] over GF(2^4), reduction polynomial x^4+x+1. InvMixColumns uses [9 2; 2 9].
- FSM states: IDLE, RND1, RND2, DONE.
  - in_ready = (state==IDLE).
  - IDLE, in_valid=1 (accept edge): register mode and K0/K1/K2 (expanded combinationally from in_key). Each lane state <= in_data ^ K0 (enc) or ^ K2 (dec). Go to RND1.
  - RND1 edge:
    - enc: state <= MixCol(ShiftRows(SubNib(state))) ^ K1.
    - dec: state <= InvMixCol(InvSubNib(InvShiftRows(state)) ^ K1).
    - Go to RND2.
  - RND2 edge:
    - enc: out_data <= ShiftRows(SubNib(state)) ^ K2.
    - dec: out_data <= InvSubNib(InvShiftRows(state)) ^ K0.
    - out_valid <= 1. Go to DONE.
  - DONE: out_data and out_valid hold stable until out_ready=1. On that edge out_valid <= 0 and state returns to IDLE; out_data keeps its last value.
- Latency: job accepted at edge T, out_valid high after edge T+2. Throughput is one job per 4 cycles when out_ready is tied high.
- No new job is accepted in RND1, RND2 or DONE; in_valid is ignored there. The source must hold in_valid and its data.
- in_* changes after acceptance do not affect the job in flight (mode and keys are latched).
- All lanes are computed identically and simultaneously; there is no inter-lane dependency.
- out_ready high while out_valid is low has no effect.

Test Plan:
- Encrypt, LANES=1: key 0x4AF5, data 0xD728, mode 0 -> out_data 0x24EC, out_valid rises 3 cycles after accept; busy high over the same window.
- Encrypt, LANES=1: key 0xA73B, data 0x6F6B -> 0x0738. Decrypt same key, data 0x0738 -> 0x6F6B. Decrypt key 0x4AF5, data 0x24EC -> 0xD728.
- LANES=2: key 0x4AF5, data {0xD728,0xD728}, enc -> {0x24EC,0x24EC}. Then dec of that result -> {0xD728,0xD728}.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_data 0x24EC and out_valid stable throughout. in_ready stays 0; in_valid pulses during that window are ignored. Completion happens on the out_ready edge.
- Key/mode change mid-job: after accepting key 0xA73B/enc/0x6F6B, drive in_key=0xFFFF and in_mode=1 during RND1 -> result is still 0x0738.
- Reset mid-operation: assert rst_n=0 asynchronously in RND2 -> out_valid=0, in_ready=1, busy=0, out_data=0 immediately. After release, a fresh 0xD728/0x4AF5 encrypt -> 0x24EC.
